// File: rtl/oled_pkg.sv
// oled_pkg: shared definitions for the 8-bit parallel OLED bus blocks.
//   - Controller opcodes used in the frame window-setup header
//   - Frame streamer state enum
//   - Header length and the header byte/dc lookup function
package oled_pkg;

  localparam logic [7:0] CMD_SET_COL   = 8'h15;
  localparam logic [7:0] CMD_SET_ROW   = 8'h75;
  localparam logic [7:0] CMD_WRITE_RAM = 8'h5C;

  localparam int unsigned HDR_LEN = 7;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_HDR_LATCH,
    ST_HDR_SEND,
    ST_FETCH,
    ST_PIX_HI_LATCH,
    ST_PIX_HI_SEND,
    ST_PIX_LO_LATCH,
    ST_PIX_LO_SEND,
    ST_DONE
  } fb_state_e;

  // Header entry for index idx: {dc, byte}. Column/row ranges span the
  // whole display, so the end values come straight from the geometry.
  function automatic logic [8:0] hdr_entry(input logic [2:0]  idx,
                                           input int unsigned cols,
                                           input int unsigned rows);
    logic [8:0] ent;
    case (idx)
      3'd0:    ent = {1'b0, CMD_SET_COL};
      3'd1:    ent = {1'b1, 8'h00};
      3'd2:    ent = {1'b1, 8'(cols - 1)};
      3'd3:    ent = {1'b0, CMD_SET_ROW};
      3'd4:    ent = {1'b1, 8'h00};
      3'd5:    ent = {1'b1, 8'(rows - 1)};
      3'd6:    ent = {1'b0, CMD_WRITE_RAM};
      default: ent = '0;
    endcase
    return ent;
  endfunction

endpackage

// File: rtl/oled_fb_writer.sv
// oled_fb_writer: streams one full frame from the framebuffer RAM to the
// 8-bit parallel OLED bus per accepted start pulse.
// Ports:
//   clk, rst_n      system clock, asynchronous active-low reset
//   init_done       init sequence complete; start is ignored while low
//   start           request one frame (sampled only in IDLE)
//   busy            high whenever the streamer is not idle
//   done            one-cycle pulse at end of frame
//   fb_addr         framebuffer read address (linear, row-major)
//   fb_data         framebuffer read data, valid one cycle after fb_addr
//   oled_cs         chip select, active low
//   oled_e          write strobe, display samples on its falling edge
//   oled_dc         0 = command byte, 1 = data byte
//   oled_dout       bus byte
// Each byte is a LATCH cycle (e=1, dc/dout change) then a SEND cycle (e=0).
module oled_fb_writer
  import oled_pkg::*;
#(
  parameter int unsigned COLS       = 128,
  parameter int unsigned ROWS       = 128,
  parameter int unsigned ADDR_WIDTH = 14
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  init_done,
  input  logic                  start,
  output logic                  busy,
  output logic                  done,
  output logic [ADDR_WIDTH-1:0] fb_addr,
  input  logic [15:0]           fb_data,
  output logic                  oled_cs,
  output logic                  oled_e,
  output logic                  oled_dc,
  output logic [7:0]            oled_dout
);

  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(COLS * ROWS - 1);
  localparam logic [2:0]            HDR_LAST  = 3'(HDR_LEN - 1);

  fb_state_e             state, state_n;
  logic [2:0]            hdr_idx, hdr_idx_n;
  logic [ADDR_WIDTH-1:0] addr_n;
  logic [7:0]            dout_q, dout_n;
  logic                  dc_q, dc_n;
  logic [7:0]            lo_q, lo_n;
  logic                  cs_q, e_q;
  logic [2:0]            hdr_sel;
  logic [8:0]            hdr_ent;

  // In IDLE the next header byte is byte 0; otherwise the one after hdr_idx.
  assign hdr_sel = (state == ST_IDLE) ? 3'd0 : hdr_idx + 3'd1;
  assign hdr_ent = hdr_entry(hdr_sel, COLS, ROWS);

  always_comb begin
    state_n   = state;
    hdr_idx_n = hdr_idx;
    addr_n    = fb_addr;
    dout_n    = dout_q;
    dc_n      = dc_q;
    lo_n      = lo_q;
    unique case (state)
      ST_IDLE: begin
        if (start && init_done) begin
          state_n   = ST_HDR_LATCH;
          hdr_idx_n = '0;
          dc_n      = hdr_ent[8];
          dout_n    = hdr_ent[7:0];
        end
      end
      ST_HDR_LATCH: state_n = ST_HDR_SEND;
      ST_HDR_SEND: begin
        if (hdr_idx == HDR_LAST) begin
          state_n = ST_FETCH;
          addr_n  = '0;
        end else begin
          state_n   = ST_HDR_LATCH;
          hdr_idx_n = hdr_idx + 3'd1;
          dc_n      = hdr_ent[8];
          dout_n    = hdr_ent[7:0];
        end
      end
      ST_FETCH: begin
        state_n = ST_PIX_HI_LATCH;
        dc_n    = 1'b1;
      end
      ST_PIX_HI_LATCH: begin
        // Both bytes are captured here: fb_data may move on after this cycle.
        state_n = ST_PIX_HI_SEND;
        dout_n  = fb_data[15:8];
        lo_n    = fb_data[7:0];
      end
      ST_PIX_HI_SEND: begin
        state_n = ST_PIX_LO_LATCH;
        dout_n  = lo_q;
      end
      ST_PIX_LO_LATCH: state_n = ST_PIX_LO_SEND;
      ST_PIX_LO_SEND: begin
        if (fb_addr == LAST_ADDR) begin
          state_n = ST_DONE;
          addr_n  = '0;
        end else begin
          state_n = ST_FETCH;
          addr_n  = fb_addr + 1'b1;
        end
      end
      ST_DONE: begin
        state_n = ST_IDLE;
        addr_n  = '0;
      end
      default: state_n = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= ST_IDLE;
      hdr_idx <= '0;
      fb_addr <= '0;
      dout_q  <= '0;
      dc_q    <= 1'b0;
      lo_q    <= '0;
      cs_q    <= 1'b1;
      e_q     <= 1'b1;
    end else begin
      state   <= state_n;
      hdr_idx <= hdr_idx_n;
      fb_addr <= addr_n;
      dout_q  <= dout_n;
      dc_q    <= dc_n;
      lo_q    <= lo_n;
      // Strobe and select are registered from the next state so they
      // switch cleanly on the clock edge.
      cs_q    <= (state_n == ST_IDLE) || (state_n == ST_DONE);
      e_q     <= !((state_n == ST_HDR_SEND) || (state_n == ST_PIX_HI_SEND) ||
                   (state_n == ST_PIX_LO_SEND));
    end
  end

  // The high byte only becomes valid in PIX_HI_LATCH itself, so it is
  // driven straight from the RAM in that cycle and from the register after.
  assign oled_dout = (state == ST_PIX_HI_LATCH) ? fb_data[15:8] : dout_q;
  assign oled_dc   = dc_q;
  assign oled_cs   = cs_q;
  assign oled_e    = e_q;
  assign busy      = (state != ST_IDLE);
  assign done      = (state == ST_DONE);

endmodule

// File: tb/tb_oled_fb_writer.sv
// Testbench for oled_fb_writer with a 2x2 display. A frame-level reference
// model tracks the frame cycle number from the published timing and derives
// every expected bus value from the header table and the framebuffer array.
module tb_oled_fb_writer;

  localparam int COLS = 2;
  localparam int ROWS = 2;
  localparam int AW   = 2;
  localparam int N    = COLS * ROWS;
  localparam int FLEN = 15 + 5 * N;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          init_done;
  logic          start;
  logic          busy;
  logic          done;
  logic [AW-1:0] fb_addr;
  logic [15:0]   fb_data;
  logic          oled_cs;
  logic          oled_e;
  logic          oled_dc;
  logic [7:0]    oled_dout;

  oled_fb_writer #(.COLS(COLS), .ROWS(ROWS), .ADDR_WIDTH(AW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .init_done (init_done),
    .start     (start),
    .busy      (busy),
    .done      (done),
    .fb_addr   (fb_addr),
    .fb_data   (fb_data),
    .oled_cs   (oled_cs),
    .oled_e    (oled_e),
    .oled_dc   (oled_dc),
    .oled_dout (oled_dout)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Header as the display expects it: bytes and their dc flags.
  logic [7:0]  hdr_b  [7];
  logic        hdr_dc [7];
  logic [15:0] mem    [N];
  logic        corrupt = 1'b0;

  initial begin
    hdr_b[0] = 8'h15; hdr_b[1] = 8'h00; hdr_b[2] = 8'(COLS - 1);
    hdr_b[3] = 8'h75; hdr_b[4] = 8'h00; hdr_b[5] = 8'(ROWS - 1);
    hdr_b[6] = 8'h5C;
    hdr_dc[0] = 1'b0; hdr_dc[1] = 1'b1; hdr_dc[2] = 1'b1; hdr_dc[3] = 1'b0;
    hdr_dc[4] = 1'b1; hdr_dc[5] = 1'b1; hdr_dc[6] = 1'b0;
  end

  // Frame model: m_cyc = 0 when idle, else the cycle number within the frame.
  int         m_cyc;
  logic [7:0] hd_dout;
  logic       hd_dc;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_cyc   = 0;
      hd_dout = 8'h00;
      hd_dc   = 1'b0;
      fb_data <= 16'h0000;
    end else begin
      if (m_cyc == 0) begin
        if (start && init_done) m_cyc = 1;
      end else if (m_cyc == FLEN) begin
        m_cyc = 0;
      end else begin
        m_cyc++;
      end
      // Synchronous-read RAM; in corrupt mode data is valid only in the
      // cycle right after each FETCH and is garbage otherwise.
      if (!corrupt)
        fb_data <= mem[fb_addr];
      else if (m_cyc >= 16 && m_cyc < FLEN && ((m_cyc - 16) % 5) == 0)
        fb_data <= mem[fb_addr];
      else
        fb_data <= 16'($urandom);
    end
  end

  always @(negedge clk) begin
    logic [7:0] ed;
    logic       edc, ee, ecs, ebusy, edone;
    int         ea, c, p, ph;
    c = m_cyc;
    ed = hd_dout; edc = hd_dc; ee = 1'b1; ecs = 1'b1;
    ebusy = 1'b0; edone = 1'b0; ea = 0;
    if (c >= 1 && c <= 14) begin
      ed = hdr_b[(c - 1) / 2]; edc = hdr_dc[(c - 1) / 2];
      ee = ((c - 1) % 2) == 0; ecs = 1'b0; ebusy = 1'b1;
    end else if (c >= 15 && c < FLEN) begin
      p = (c - 15) / 5; ph = (c - 15) % 5;
      ea = p; ecs = 1'b0; ebusy = 1'b1;
      if (ph == 1 || ph == 2) begin
        ed = mem[p][15:8]; edc = 1'b1; ee = (ph == 1);
      end else if (ph == 3 || ph == 4) begin
        ed = mem[p][7:0];  edc = 1'b1; ee = (ph == 3);
      end
    end else if (c == FLEN) begin
      ebusy = 1'b1; edone = 1'b1;
    end
    check_eq("oled_cs",   32'(oled_cs),   32'(ecs));
    check_eq("oled_e",    32'(oled_e),    32'(ee));
    check_eq("oled_dc",   32'(oled_dc),   32'(edc));
    check_eq("oled_dout", 32'(oled_dout), 32'(ed));
    check_eq("fb_addr",   32'(fb_addr),   32'(ea));
    check_eq("busy",      32'(busy),      32'(ebusy));
    check_eq("done",      32'(done),      32'(edone));
    hd_dout = ed;
    hd_dc   = edc;
  end

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  initial begin
    rst_n = 1'b0; init_done = 1'b0; start = 1'b0;
    mem[0] = 16'h1234; mem[1] = 16'h5678; mem[2] = 16'h9ABC; mem[3] = 16'hDEF0;

    // Reset held: start toggling must do nothing.
    @(negedge clk);
    init_done = 1'b1;
    for (int i = 0; i < 6; i++) begin
      start = i[0];
      @(negedge clk);
    end
    start = 1'b0; init_done = 1'b0;
    rst_n = 1'b1;
    idle_cycles(2);

    // init_done low: start ignored.
    start = 1'b1;
    idle_cycles(4);
    start = 1'b0;
    idle_cycles(2);

    // Single frame with the fixed pattern.
    init_done = 1'b1;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    idle_cycles(FLEN + 4);

    // Start held high: back-to-back frames, then stop.
    start = 1'b1;
    idle_cycles(FLEN + 10);
    start = 1'b0;
    idle_cycles(FLEN + 4);

    // Async reset during PIX_HI_SEND of pixel 2 (frame cycle 27).
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 200 && m_cyc != 27; i++) @(negedge clk);
    check_eq("reach_pix2_hi_send", 32'(m_cyc), 32'd27);
    #2 rst_n = 1'b0;
    #1;
    check_eq("arst_cs",   32'(oled_cs), 32'd1);
    check_eq("arst_e",    32'(oled_e),  32'd1);
    check_eq("arst_addr", 32'(fb_addr), 32'd0);
    check_eq("arst_busy", 32'(busy),    32'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    idle_cycles(2);

    // Restart after abort; drop init_done mid-frame (must not matter).
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    idle_cycles(10);
    init_done = 1'b0;
    idle_cycles(FLEN);
    init_done = 1'b1;
    idle_cycles(3);

    // Randomized frames, RAM data only valid right after FETCH.
    corrupt = 1'b1;
    for (int i = 0; i < 600; i++) begin
      if (m_cyc == 0)
        for (int j = 0; j < N; j++) mem[j] = 16'($urandom);
      start     = ($urandom_range(0, 3) == 0);
      init_done = ($urandom_range(0, 7) != 0);
      @(negedge clk);
    end
    start = 1'b0;
    idle_cycles(FLEN + 2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
